// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory access plus MEM->WB pipeline stage of an RV32 core.
//
// Holds a DMEM_WORDS x 32-bit data memory with byte-lane stores (SB/SH/SW)
// and a synchronous read register for loads. It also holds the M->W pipeline
// registers. Load data is extracted and sign/zero extended combinationally
// on the W side. resultW picks ALU, load data or PC_next.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   writebackM    writeback select (00/11 ALU, 01 load, 10 PC_next)
//   funcM         RV32 funct3 (B/H/W/BU/HU)
//   load_storeM   1 store, 0 load
//   en_dmemM      data memory access enable
//   wen_rfM       register-file write enable
//   alu_resultM   ALU result / byte address (bits [7:2] index the memory)
//   out_rf2M      store data
//   rdM           destination register
//   PC_nextM      PC+4
//   wen_rfW, rdW, resultW, misalignW  writeback-side outputs
//
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, misaligned
// halfword/word accesses are flagged on misalignW, misaligned stores are
// dropped and misaligned loads do not write the register file.
module mem_wb_stage #(
  parameter int unsigned DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  writebackM,
  input  logic [2:0]  funcM,
  input  logic        load_storeM,
  input  logic        en_dmemM,
  input  logic        wen_rfM,
  input  logic [31:0] alu_resultM,
  input  logic [31:0] out_rf2M,
  input  logic [4:0]  rdM,
  input  logic [7:0]  PC_nextM,
  output logic        wen_rfW,
  output logic [4:0]  rdW,
  output logic [31:0] resultW,
  output logic        misalignW
);

  localparam int unsigned AW = $clog2(DMEM_WORDS);

  logic [31:0]   mem_q [DMEM_WORDS];
  logic [AW-1:0] idx;

  logic [3:0]  store_be;
  logic [31:0] store_data;
  logic        store_en;
  logic        load_en;
  logic        misalign_m;
  logic        wen_rf_d;

  logic [1:0]  writeback_q;
  logic [2:0]  func_q;
  logic [1:0]  addr_lo_q;
  logic        wen_rf_q;
  logic [4:0]  rd_q;
  logic [31:0] alu_result_q;
  logic [7:0]  pc_next_q;
  logic        misalign_q;
  logic [31:0] rdata_q;

  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  // Higher address bits are ignored, so out-of-range addresses wrap.
  assign idx = alu_resultM[AW+1:2];

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misalign_m = 1'b0;
    if (en_dmemM) begin
      case (funcM)
        3'b001, 3'b101: misalign_m = alu_resultM[0];
        3'b010:         misalign_m = (alu_resultM[1:0] != 2'b00);
        default:        misalign_m = 1'b0;
      endcase
    end
  end
`else
  assign misalign_m = 1'b0;
`endif

  // Narrow store data is replicated across the word so that the byte
  // enables alone decide which lanes change.
  always_comb begin
    store_be   = 4'b0000;
    store_data = out_rf2M;
    case (funcM)
      3'b000: begin
        store_be   = 4'b0001 << alu_resultM[1:0];
        store_data = {4{out_rf2M[7:0]}};
      end
      3'b001: begin
        store_be   = alu_resultM[1] ? 4'b1100 : 4'b0011;
        store_data = {2{out_rf2M[15:0]}};
      end
      3'b010:  store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  end

  assign store_en = en_dmemM & load_storeM & ~misalign_m;
  assign load_en  = en_dmemM & ~load_storeM;

  // A misaligned load must not write the register file.
  assign wen_rf_d = wen_rfM & ~(misalign_m & ~load_storeM);

  // Memory is not reset; a store on an edge with rst asserted is dropped.
  always_ff @(posedge clk) begin
    if (!rst && store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (store_be[i]) begin
          mem_q[idx][8*i +: 8] <= store_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      writeback_q  <= 2'b00;
      func_q       <= 3'b000;
      addr_lo_q    <= 2'b00;
      wen_rf_q     <= 1'b0;
      rd_q         <= 5'd0;
      alu_result_q <= 32'd0;
      pc_next_q    <= 8'd0;
      misalign_q   <= 1'b0;
      rdata_q      <= 32'd0;
    end else begin
      writeback_q  <= writebackM;
      func_q       <= funcM;
      addr_lo_q    <= alu_resultM[1:0];
      wen_rf_q     <= wen_rf_d;
      rd_q         <= rdM;
      alu_result_q <= alu_resultM;
      pc_next_q    <= PC_nextM;
      misalign_q   <= misalign_m;
      if (load_en) begin
        rdata_q <= mem_q[idx];
      end
    end
  end

  assign load_byte = rdata_q[8*addr_lo_q +: 8];
  assign load_half = addr_lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    load_data = rdata_q;
    case (func_q)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_data = {24'd0, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b101:  load_data = {16'd0, load_half};
      default: load_data = rdata_q;
    endcase
  end

  always_comb begin
    resultW = alu_result_q;
    case (writeback_q)
      2'b01:   resultW = load_data;
      2'b10:   resultW = {24'd0, pc_next_q};
      default: resultW = alu_result_q;
    endcase
  end

  assign wen_rfW   = wen_rf_q;
  assign rdW       = rd_q;
  assign misalignW = misalign_q;

endmodule
